// File: rtl/dst_scoreboard_pkg.sv
// Purpose: opcode and register constants shared by the destination scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dst_scoreboard_pkg;

    // Opcodes. R-type ALU ops all share IROP; the function field is irrelevant here.
    localparam logic [5:0] IROP  = 6'b000000;
    localparam logic [5:0] IJAL  = 6'b000011;
    localparam logic [5:0] IBEQ  = 6'b000100;
    localparam logic [5:0] IBNE  = 6'b000101;
    localparam logic [5:0] IADDI = 6'b001000;
    localparam logic [5:0] ISLTI = 6'b001010;
    localparam logic [5:0] IANDI = 6'b001100;
    localparam logic [5:0] IORI  = 6'b001101;
    localparam logic [5:0] ILUI  = 6'b001111;
    localparam logic [5:0] ILW   = 6'b100011;
    localparam logic [5:0] ISW   = 6'b101011;

    // Register 0 doubles as "no destination"; it never takes part in a hazard.
    localparam int RNONE  = 0;
    localparam int REG_RA = 31;

endpackage

// File: rtl/dst_scoreboard_dst_decode.sv
// Purpose: decode the Decode-stage instruction into ALU/load destinations and source usage.
// Latency: purely combinational.
// Backpressure: none; d_valid = 0 yields no destinations.
// Ports: op/rt/rd/valid in; dst_e, dst_m, rs_used, rt_used out.
module dst_decode
    import dst_scoreboard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [5:0]       op,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             valid,
    output logic [REG_W-1:0] dst_e,
    output logic [REG_W-1:0] dst_m,
    output logic             rs_used,
    output logic             rt_used
);

    always_comb begin
        dst_e = REG_W'(RNONE);
        dst_m = REG_W'(RNONE);
        if (valid) begin
            case (op)
                IROP:                             dst_e = rd;
                IADDI, IANDI, IORI, ISLTI, ILUI: dst_e = rt;
                IJAL:                             dst_e = REG_W'(REG_RA);
                ILW:                              dst_m = rt;
                default: ;
            endcase
        end
    end

    always_comb begin
        rs_used = !(op == IJAL || op == ILUI);
        rt_used = (op == IROP) || (op == ISW) || (op == IBEQ) || (op == IBNE);
    end

endmodule

// File: rtl/dst_scoreboard.sv
// Purpose: track in-flight destinations, produce per-source forward selects and load-use stall.
// Latency: destination visible in stage 0 one cycle after leaving Decode; hazard outputs combinational.
// Backpressure: stall_in freezes every stage; load_use_stall/flush insert a bubble into stage 0.
// Ports: clk, rst_n, D_op/D_rs/D_rt/D_rd/d_valid/stall_in/flush in;
//        d_dstE/d_dstM, fwd_a_sel/fwd_b_sel, load_use_stall, stage_dstE/stage_dstM out.
module dst_scoreboard
    import dst_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int LOAD_USE_DEPTH = 1,
    parameter int REG_W          = 5,
    parameter int SEL_W          = $clog2(NUM_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  D_op,
    input  logic [REG_W-1:0]            D_rs,
    input  logic [REG_W-1:0]            D_rt,
    input  logic [REG_W-1:0]            D_rd,
    input  logic                        d_valid,
    input  logic                        stall_in,
    input  logic                        flush,
    output logic [REG_W-1:0]            d_dstE,
    output logic [REG_W-1:0]            d_dstM,
    output logic [SEL_W-1:0]            fwd_a_sel,
    output logic [SEL_W-1:0]            fwd_b_sel,
    output logic                        load_use_stall,
    output logic [NUM_STAGES*REG_W-1:0] stage_dstE,
    output logic [NUM_STAGES*REG_W-1:0] stage_dstM
);

    logic             rs_used;
    logic             rt_used;
    logic [REG_W-1:0] st_e [NUM_STAGES];
    logic [REG_W-1:0] st_m [NUM_STAGES];

    dst_decode #(.REG_W(REG_W)) u_decode (
        .op      (D_op),
        .rt      (D_rt),
        .rd      (D_rd),
        .valid   (d_valid),
        .dst_e   (d_dstE),
        .dst_m   (d_dstM),
        .rs_used (rs_used),
        .rt_used (rt_used)
    );

    // Source 0 = rs (port A), source 1 = rt (port B).
    logic [REG_W-1:0] src_reg  [2];
    logic             src_used [2];
    logic [SEL_W-1:0] src_sel  [2];
    logic             src_stl  [2];

    assign src_reg[0]  = D_rs;
    assign src_reg[1]  = D_rt;
    assign src_used[0] = rs_used;
    assign src_used[1] = rt_used;

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [NUM_STAGES-1:0] hit_e;
        logic [NUM_STAGES-1:0] hit_m;
        logic                  live;

        // Register 0 is the "none" marker, so it must never be treated as a match.
        assign live = src_used[s] && (src_reg[s] != REG_W'(RNONE));

        for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
            assign hit_e[i] = live && (st_e[i] == src_reg[s]);
            assign hit_m[i] = live && (st_m[i] == src_reg[s]);
        end

        // Youngest match decides; a load still in the unavailable window stalls
        // instead of forwarding, even if an older stage also holds the register.
        always_comb begin
            logic found;
            found      = 1'b0;
            src_sel[s] = '0;
            src_stl[s] = 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (!found && (hit_e[i] || hit_m[i])) begin
                    found = 1'b1;
                    if (hit_m[i] && (i < LOAD_USE_DEPTH)) begin
                        src_stl[s] = 1'b1;
                    end else begin
                        src_sel[s] = SEL_W'(i + 1);
                    end
                end
            end
        end
    end

    assign fwd_a_sel      = src_sel[0];
    assign fwd_b_sel      = src_sel[1];
    assign load_use_stall = d_valid && !flush && (src_stl[0] || src_stl[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                st_e[i] <= REG_W'(RNONE);
                st_m[i] <= REG_W'(RNONE);
            end
        end else if (!stall_in) begin
            for (int i = 1; i < NUM_STAGES; i++) begin
                st_e[i] <= st_e[i-1];
                st_m[i] <= st_m[i-1];
            end
            if (load_use_stall || flush) begin
                st_e[0] <= REG_W'(RNONE);
                st_m[0] <= REG_W'(RNONE);
            end else begin
                st_e[0] <= d_dstE;
                st_m[0] <= d_dstM;
            end
        end
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_flat
        assign stage_dstE[i*REG_W +: REG_W] = st_e[i];
        assign stage_dstM[i*REG_W +: REG_W] = st_m[i];
    end

endmodule

// File: tb/tb_dst_scoreboard.sv
// Purpose: directed self-checking bench for dst_scoreboard (default parameters N=3, LUD=1).
// Latency: inputs applied 2 ns after a rising edge, outputs sampled mid-cycle.
// Backpressure: exercised through stall_in, flush and load-use sequences.
module tb_dst_scoreboard;
    import dst_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  D_op;
    logic [4:0]  D_rs, D_rt, D_rd;
    logic        d_valid, stall_in, flush;
    logic [4:0]  d_dstE, d_dstM;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        load_use_stall;
    logic [14:0] stage_dstE, stage_dstM;

    int checks = 0;
    int errors = 0;

    dst_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .D_op           (D_op),
        .D_rs           (D_rs),
        .D_rt           (D_rt),
        .D_rd           (D_rd),
        .d_valid        (d_valid),
        .stall_in       (stall_in),
        .flush          (flush),
        .d_dstE         (d_dstE),
        .d_dstM         (d_dstM),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .load_use_stall (load_use_stall),
        .stage_dstE     (stage_dstE),
        .stage_dstM     (stage_dstM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        D_op = op; D_rs = rs; D_rt = rt; D_rd = rd; d_valid = 1'b1;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; D_op = IROP; D_rs = 0; D_rt = 0; D_rd = 0;
        d_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        tick;
        chk("reset_stageE", stage_dstE, 0);
        chk("reset_stageM", stage_dstM, 0);
        chk("reset_stall", load_use_stall, 0);
        rst_n = 1'b1;

        // Forward priority: ADDI r8, OR r8, then R-type reading r8.
        drive(IADDI, 1, 8, 0);
        chk("addi_dstE", d_dstE, 8);
        chk("addi_dstM", d_dstM, 0);
        tick;
        chk("addi_stage0", stage_dstE, 8);
        drive(IROP, 2, 3, 8);
        chk("or_dstE", d_dstE, 8);
        chk("or_sel_a_nomatch", fwd_a_sel, 0);
        tick;
        chk("or_stages", stage_dstE, 15'h108);
        drive(IROP, 8, 9, 10);
        chk("prio_sel_a", fwd_a_sel, 1);
        chk("prio_sel_b", fwd_b_sel, 0);
        chk("prio_stall", load_use_stall, 0);
        tick;
        chk("prio_stages", stage_dstE, 15'h210A);

        // Load-use: LW r5 followed by ADD rs=5 (rt=8 still in stage 2).
        drive(ILW, 0, 5, 0);
        chk("lw_dstM", d_dstM, 5);
        chk("lw_dstE", d_dstE, 0);
        tick;
        drive(IROP, 5, 8, 11);
        chk("lu_stall", load_use_stall, 1);
        chk("lu_sel_a", fwd_a_sel, 0);
        chk("lu_sel_b_stage2", fwd_b_sel, 3);
        tick;
        chk("lu_bubble_E", stage_dstE, 15'd10240);
        chk("lu_bubble_M", stage_dstM, 15'd160);
        chk("lu_release_stall", load_use_stall, 0);
        chk("lu_release_sel_a", fwd_a_sel, 2);
        tick;
        chk("lu_after_E", stage_dstE, 15'd11);
        chk("lu_after_M", stage_dstM, 15'd5120);

        // Zero register never matches.
        drive(IADDI, 1, 0, 0);
        chk("r0_dstE", d_dstE, 0);
        tick;
        drive(IROP, 0, 0, 12);
        chk("r0_sel_a", fwd_a_sel, 0);
        chk("r0_sel_b", fwd_b_sel, 0);
        chk("r0_stall", load_use_stall, 0);
        tick;

        // Freeze with ADDI r7 in stage 0.
        drive(IADDI, 1, 7, 0);
        tick;
        chk("frz_pre", stage_dstE, 15'd391);
        stall_in = 1'b1;
        drive(IADDI, 1, 9, 0);
        tick;
        chk("frz_c1", stage_dstE, 15'd391);
        tick;
        chk("frz_c2", stage_dstE, 15'd391);
        tick;
        chk("frz_c3", stage_dstE, 15'd391);
        stall_in = 1'b0;
        tick;
        chk("frz_shift", stage_dstE, 15'd12521);

        // Hold vs load-use, then flush vs load-use.
        drive(ILW, 0, 6, 0);
        tick;
        chk("lw6_stageM", stage_dstM, 15'd6);
        stall_in = 1'b1;
        drive(IROP, 6, 0, 13);
        chk("hold_lu_stall", load_use_stall, 1);
        tick;
        chk("hold_lu_M", stage_dstM, 15'd6);
        chk("hold_lu_E", stage_dstE, 15'd7456);
        stall_in = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_stall", load_use_stall, 0);
        tick;
        flush = 1'b0;
        chk("flush_bubble_M", stage_dstM, 15'd192);
        chk("flush_bubble_E", stage_dstE, 15'd9216);

        // JAL / SW / BEQ decode.
        drive(IJAL, 6, 0, 0);
        chk("jal_dstE", d_dstE, 31);
        chk("jal_rs_unused", fwd_a_sel, 0);
        drive(ISW, 1, 5, 0);
        chk("sw_dstE", d_dstE, 0);
        chk("sw_dstM", d_dstM, 0);
        drive(IBEQ, 1, 2, 3);
        chk("beq_dstE", d_dstE, 0);
        drive(IROP, 1, 2, 3);
        d_valid = 1'b0;
        #1;
        chk("invalid_dstE", d_dstE, 0);

        // Build stages 8/9/10 (stage 0 is LW r8), then reset mid-cycle.
        drive(IADDI, 1, 10, 0);
        tick;
        drive(IADDI, 1, 9, 0);
        tick;
        drive(ILW, 1, 8, 0);
        tick;
        drive(IROP, 8, 9, 14);
        chk("pre_rst_E", stage_dstE, 15'd10528);
        chk("pre_rst_M", stage_dstM, 15'd8);
        chk("pre_rst_stall", load_use_stall, 1);
        chk("pre_rst_sel_b", fwd_b_sel, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_E", stage_dstE, 0);
        chk("rst_M", stage_dstM, 0);
        chk("rst_stall", load_use_stall, 0);
        chk("rst_sel_a", fwd_a_sel, 0);
        chk("rst_sel_b", fwd_b_sel, 0);
        tick;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
